// File: rtl/au_inc_gray_sched.sv
// Round-robin scheduler time-sharing one Gray incrementer across NCH channel counters.
// Optional binary copy of z (port z_bin) when AU_INC_GRAY_SCHED_BIN_OUT_EN is defined.

module au_inc_gray_sched_inc #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  generate
    if (ARCH == 1) begin : g_direct
      // Pure Gray step: even parity flips bit 0, odd parity flips the bit
      // left of the lowest set bit (or the MSB itself when it is the lowest).
      logic [WIDTH-1:0] lowbit;
      always_comb begin
        lowbit = a & (~a + WIDTH'(1));
        if (!(^a))                   y = a ^ WIDTH'(1);
        else if (lowbit[WIDTH-1])    y = a ^ lowbit;
        else                         y = a ^ (lowbit << 1);
      end
    end else if (ARCH == 2) begin : g_ripple
      logic [WIDTH-1:0] b, s;
      logic             c;
      always_comb begin
        b = gray2bin(a);
        s = '0;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          s[i] = b[i] ^ c;
          c    = b[i] & c;
        end
        y = bin2gray(s);
      end
    end else begin : g_conv
      assign y = bin2gray(gray2bin(a) + WIDTH'(1));
    end
  endgenerate

endmodule

module au_inc_gray_sched #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int ARCH  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         clr,
  output logic [NCH-1:0]         gnt,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] gnt_id,
  output logic [WIDTH-1:0]       z,
  output logic                   wrap,
  output logic [NCH*WIDTH-1:0]   cnt
`ifdef AU_INC_GRAY_SCHED_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0]       z_bin
`endif
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] GMAX = WIDTH'(1) << (WIDTH - 1);

  logic [NCH-1:0][WIDTH-1:0] cnt_r;
  logic [IDW-1:0]            p, win, nxt_p;
  logic [NCH-1:0]            elig, win_oh;
  logic                      found;
  logic [WIDTH-1:0]          cur, inc_y;
  int                        idx;

  assign elig = en ? (req & ~clr) : '0;
  assign cnt  = cnt_r;

  // Rotating priority search starting at p.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(p) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && elig[idx]) begin
        found       = 1'b1;
        win         = IDW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign nxt_p = (win == IDW'(NCH - 1)) ? '0 : win + IDW'(1);
  assign cur   = cnt_r[win];

  au_inc_gray_sched_inc #(.WIDTH(WIDTH), .ARCH(ARCH)) u_inc (
    .a (cur),
    .y (inc_y)
  );

`ifdef AU_INC_GRAY_SCHED_BIN_OUT_EN
  logic [WIDTH-1:0] inc_bin;
  always_comb begin
    inc_bin = inc_y;
    for (int i = WIDTH - 2; i >= 0; i--) inc_bin[i] = inc_bin[i+1] ^ inc_y[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      z      <= '0;
      wrap   <= 1'b0;
      p      <= '0;
`ifdef AU_INC_GRAY_SCHED_BIN_OUT_EN
      z_bin  <= '0;
`endif
    end else begin
      // Cleared channels are never eligible, so clear and grant never collide.
      for (int k = 0; k < NCH; k++) begin
        if (clr[k])                          cnt_r[k] <= '0;
        else if (found && win == IDW'(k))    cnt_r[k] <= inc_y;
      end
      gnt  <= win_oh;
      wrap <= found && (cur == GMAX);
      if (found) begin
        gnt_id <= win;
        z      <= inc_y;
        p      <= nxt_p;
`ifdef AU_INC_GRAY_SCHED_BIN_OUT_EN
        z_bin  <= inc_bin;
`endif
      end
    end
  end

endmodule
